// File: rtl/fx3_slave_fifo_responder.sv
// FX3 slave-FIFO responder: channel 0 buffers FPGA writes for the host; channel 1 serves host commands on DQ.
// Optional FX3_FLAG_DELAY_EN adds two register stages on the four DMA flags to model FX3 flag lag.
module fx3_slave_fifo_responder #(
  parameter int unsigned BUF_WORDS = 1024,
  parameter int unsigned WM_WORDS  = 4,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        USB_CLK,
  input  logic        rst_n,
  input  logic        WR,
  input  logic        RD,
  input  logic        OE,
  input  logic        LastWRData,
  inout  wire  [15:0] DQ,
  output logic        DMA0_Ready,
  output logic        DMA0_Watermark,
  output logic        DMA1_Ready,
  output logic        DMA1_Watermark,
  output logic [15:0] h_tx_data,
  output logic        h_tx_valid,
  output logic        h_tx_last,
  input  logic        h_tx_ready,
  input  logic [15:0] h_rx_data,
  input  logic        h_rx_valid,
  input  logic        h_rx_last,
  output logic        h_rx_ready,
  output logic        err_ovf,
  output logic        err_proto
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = $clog2(BUF_WORDS);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = RD_LAT;
  localparam logic [CW-1:0] LAST_CNT = CW'(BUF_WORDS - 1);
  localparam logic [CW-1:0] WM0_CNT  = CW'(BUF_WORDS - WM_WORDS);
  localparam logic [CW-1:0] WM1_CNT  = CW'(WM_WORDS);

  typedef enum logic {C0_FILL, C0_DRAIN} c0_state_t;
  typedef enum logic {C1_LOAD, C1_AVAIL} c1_state_t;

  c0_state_t c0_state;
  c1_state_t c1_state;

  logic [DW-1:0] mem0 [BUF_WORDS];
  logic [DW-1:0] mem1 [BUF_WORDS];

  logic [PW-1:0] wptr0, rptr0, wptr1, rptr1;
  logic [CW-1:0] cnt0, cnt1, req1;
  logic [LW-1:0] rd_pipe;
  logic [DW-1:0] dq_q;

  logic dma0_ready_q, dma0_wm_q, dma1_ready_q, dma1_wm_q;

  logic wr_acc, rx_acc, rd_acc, pop1;

  assign DQ = OE ? dq_q : {DW{1'bz}};

  // Accepted transfers; WR together with RD or OE is a protocol error and does nothing.
  assign wr_acc = WR & ~RD & ~OE & (c0_state == C0_FILL);
  assign rx_acc = h_rx_valid & h_rx_ready & (c1_state == C1_LOAD);
  assign rd_acc = RD & ~WR & (c1_state == C1_AVAIL) & (req1 != '0);
  assign pop1   = rd_pipe[LW-1];

  // Buffer storage; emptiness is tracked by pointers and counters only.
  always_ff @(posedge USB_CLK) begin
    if (wr_acc) mem0[wptr0] <= DQ;
    if (rx_acc) mem1[wptr1] <= h_rx_data;
  end

  // Channel 0: FPGA writes fill the buffer, then the committed packet drains to h_tx.
  always_ff @(posedge USB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      c0_state     <= C0_FILL;
      wptr0        <= '0;
      rptr0        <= '0;
      cnt0         <= '0;
      dma0_ready_q <= 1'b0;
      dma0_wm_q    <= 1'b0;
      h_tx_data    <= '0;
      h_tx_valid   <= 1'b0;
      h_tx_last    <= 1'b0;
    end else begin
      case (c0_state)
        C0_FILL: begin
          dma0_ready_q <= 1'b1;
          dma0_wm_q    <= (cnt0 >= WM0_CNT);
          if (wr_acc) begin
            wptr0     <= wptr0 + PW'(1);
            cnt0      <= cnt0 + CW'(1);
            dma0_wm_q <= ((cnt0 + CW'(1)) >= WM0_CNT);
            if (LastWRData || (cnt0 == LAST_CNT)) begin
              c0_state     <= C0_DRAIN;
              dma0_ready_q <= 1'b0;
              dma0_wm_q    <= 1'b0;
            end
          end
        end
        C0_DRAIN: begin
          dma0_ready_q <= 1'b0;
          dma0_wm_q    <= 1'b0;
          if (h_tx_valid && h_tx_ready && h_tx_last) begin
            c0_state     <= C0_FILL;
            h_tx_valid   <= 1'b0;
            h_tx_last    <= 1'b0;
            cnt0         <= '0;
            dma0_ready_q <= 1'b1;
          end else if ((!h_tx_valid || h_tx_ready) && (cnt0 != '0)) begin
            h_tx_data  <= mem0[rptr0];
            h_tx_valid <= 1'b1;
            h_tx_last  <= (cnt0 == CW'(1));
            rptr0      <= rptr0 + PW'(1);
            cnt0       <= cnt0 - CW'(1);
          end
        end
      endcase
    end
  end

  // Channel 1: load a host packet, then serve it on DQ through an RD_LAT-deep token pipe.
  // req1 counts words not yet requested so in-flight reads can never over-pop.
  always_ff @(posedge USB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      c1_state     <= C1_LOAD;
      wptr1        <= '0;
      rptr1        <= '0;
      cnt1         <= '0;
      req1         <= '0;
      rd_pipe      <= '0;
      dq_q         <= '0;
      h_rx_ready   <= 1'b0;
      dma1_ready_q <= 1'b0;
      dma1_wm_q    <= 1'b0;
    end else begin
      rd_pipe <= LW'({rd_pipe, rd_acc});
      case (c1_state)
        C1_LOAD: begin
          h_rx_ready   <= 1'b1;
          dma1_ready_q <= 1'b0;
          dma1_wm_q    <= 1'b0;
          if (rx_acc) begin
            wptr1 <= wptr1 + PW'(1);
            cnt1  <= cnt1 + CW'(1);
            req1  <= req1 + CW'(1);
            if (h_rx_last || (cnt1 == LAST_CNT)) begin
              c1_state     <= C1_AVAIL;
              h_rx_ready   <= 1'b0;
              dma1_ready_q <= 1'b1;
              dma1_wm_q    <= ((cnt1 + CW'(1)) <= WM1_CNT);
            end
          end
        end
        C1_AVAIL: begin
          h_rx_ready   <= 1'b0;
          dma1_ready_q <= 1'b1;
          dma1_wm_q    <= (cnt1 <= WM1_CNT);
          if (rd_acc) req1 <= req1 - CW'(1);
          if (pop1) begin
            dq_q      <= mem1[rptr1];
            rptr1     <= rptr1 + PW'(1);
            cnt1      <= cnt1 - CW'(1);
            dma1_wm_q <= ((cnt1 - CW'(1)) <= WM1_CNT);
            if (cnt1 == CW'(1)) begin
              c1_state     <= C1_LOAD;
              h_rx_ready   <= 1'b1;
              dma1_ready_q <= 1'b0;
              dma1_wm_q    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge USB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      err_ovf   <= err_ovf | (WR & ~RD & (c0_state == C0_DRAIN));
      err_proto <= err_proto | (WR & (RD | OE));
    end
  end

`ifdef FX3_FLAG_DELAY_EN
  logic [3:0] flag_d1, flag_d2;

  always_ff @(posedge USB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      flag_d1 <= '0;
      flag_d2 <= '0;
    end else begin
      flag_d1 <= {dma0_ready_q, dma0_wm_q, dma1_ready_q, dma1_wm_q};
      flag_d2 <= flag_d1;
    end
  end

  assign {DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark} = flag_d2;
`else
  assign {DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark} =
         {dma0_ready_q, dma0_wm_q, dma1_ready_q, dma1_wm_q};
`endif

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// Self-checking bench for fx3_slave_fifo_responder: queue-based packet model, randomized data, stalls and gaps.
module tb_fx3_slave_fifo_responder;

  localparam int unsigned BUF_WORDS = 1024;
  localparam int unsigned WM_WORDS  = 4;
  localparam int unsigned RD_LAT    = 2;

  logic        USB_CLK = 1'b0;
  logic        rst_n;
  logic        WR, RD, OE, LastWRData;
  wire  [15:0] DQ;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  logic        DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark;
  logic [15:0] h_tx_data;
  logic        h_tx_valid, h_tx_last, h_tx_ready;
  logic [15:0] h_rx_data;
  logic        h_rx_valid, h_rx_last, h_rx_ready;
  logic        err_ovf, err_proto;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wr_q[$];
  logic [15:0] hq[$];
  logic [15:0] got_data[$];
  bit          got_last[$];

  assign DQ = tb_dq_en ? tb_dq : 16'hzzzz;

  always #5 USB_CLK = ~USB_CLK;

  fx3_slave_fifo_responder #(
    .BUF_WORDS(BUF_WORDS), .WM_WORDS(WM_WORDS), .RD_LAT(RD_LAT)
  ) dut (
    .USB_CLK(USB_CLK), .rst_n(rst_n), .WR(WR), .RD(RD), .OE(OE), .LastWRData(LastWRData),
    .DQ(DQ), .DMA0_Ready(DMA0_Ready), .DMA0_Watermark(DMA0_Watermark),
    .DMA1_Ready(DMA1_Ready), .DMA1_Watermark(DMA1_Watermark),
    .h_tx_data(h_tx_data), .h_tx_valid(h_tx_valid), .h_tx_last(h_tx_last), .h_tx_ready(h_tx_ready),
    .h_rx_data(h_rx_data), .h_rx_valid(h_rx_valid), .h_rx_last(h_rx_last), .h_rx_ready(h_rx_ready),
    .err_ovf(err_ovf), .err_proto(err_proto)
  );

  task automatic tick();
    @(negedge USB_CLK);
  endtask

  // Drives wr_q[start..] as WR beats, optionally with idle gaps, committing on the final word.
  task automatic write_words(input int start, input bit commit, input bit gaps);
    int i;
    i = start;
    while (i < wr_q.size()) begin
      if (gaps && ($urandom % 4 == 0)) begin
        WR = 1'b0; tb_dq_en = 1'b0; LastWRData = 1'b0;
      end else begin
        WR = 1'b1; tb_dq_en = 1'b1; tb_dq = wr_q[i];
        LastWRData = commit && (i == wr_q.size() - 1);
        i++;
      end
      tick();
    end
    WR = 1'b0; LastWRData = 1'b0; tb_dq_en = 1'b0;
  endtask

  // Collects accepted h_tx beats under random back-pressure until the last beat is taken.
  task automatic drain_collect(input int budget, output bit timed_out, output int stall_err);
    logic [15:0] held;
    bit pending, done;
    got_data.delete(); got_last.delete();
    stall_err = 0; pending = 0; done = 0; held = '0;
    for (int c = 0; c < budget && !done; c++) begin
      if (pending && (h_tx_valid !== 1'b1 || h_tx_data !== held)) stall_err++;
      h_tx_ready = ($urandom % 3) != 0;
      if (h_tx_valid && h_tx_ready) begin
        got_data.push_back(h_tx_data);
        got_last.push_back(h_tx_last);
        pending = 0;
        if (h_tx_last) done = 1;
      end else if (h_tx_valid) begin
        pending = 1; held = h_tx_data;
      end
      tick();
    end
    h_tx_ready = 1'b0;
    timed_out = !done;
  endtask

  // Pushes hq as one host command packet.
  task automatic host_send(input bit gaps, output bit timed_out);
    int sent, guard;
    bit acc;
    sent = 0; guard = 0;
    while (sent < hq.size() && guard < 1000) begin
      h_rx_valid = !gaps || ($urandom % 4 != 0);
      h_rx_data  = hq[sent];
      h_rx_last  = (sent == hq.size() - 1);
      acc = h_rx_valid && h_rx_ready;
      tick();
      guard++;
      if (acc) sent++;
    end
    h_rx_valid = 1'b0; h_rx_last = 1'b0;
    timed_out = sent < hq.size();
  endtask

  task automatic test_reset();
    WR = 0; RD = 0; OE = 0; LastWRData = 0; tb_dq_en = 0; tb_dq = '0;
    h_tx_ready = 0; h_rx_valid = 0; h_rx_last = 0; h_rx_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark, h_tx_valid, h_tx_last,
         h_rx_ready, err_ovf, err_proto} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs: flags still high during reset");
    end
    n_tests++;
    if (h_tx_data !== 16'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0000", h_tx_data); end
    OE = 1'b1; #1;
    n_tests++;
    if (DQ !== 16'h0) begin n_fail++; $display("FAIL reset_dq: got %h expected 0000", DQ); end
    OE = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (DMA0_Ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", DMA0_Ready); end
    tick();
    n_tests++;
    if (DMA0_Ready !== 1'b1) begin n_fail++; $display("FAIL ready_first_edge: got %b expected 1", DMA0_Ready); end
    n_tests++;
    if ({DMA0_Watermark, DMA1_Ready, DMA1_Watermark} !== 3'b0) begin
      n_fail++; $display("FAIL idle_flags: got %b expected 000", {DMA0_Watermark, DMA1_Ready, DMA1_Watermark});
    end
    n_tests++;
    if (h_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_idle: got %b expected 1", h_rx_ready); end
  endtask

  task automatic test_short_packet();
    bit to; int se, bad;
    wr_q.delete();
    for (int i = 0; i < 640; i++) wr_q.push_back(16'(i));
    write_words(0, 1'b1, 1'b0);
    n_tests++;
    if (DMA0_Ready !== 1'b0) begin n_fail++; $display("FAIL short_ready_drop: got %b expected 0", DMA0_Ready); end
    drain_collect(4000, to, se);
    n_tests++;
    if (to || got_data.size() != 640) begin
      n_fail++; $display("FAIL short_count: got %0d words expected 640 (timeout %0b)", got_data.size(), to);
    end
    bad = 0;
    for (int i = 0; i < got_data.size() && i < 640; i++)
      if (got_data[i] !== wr_q[i] || got_last[i] !== (i == 639)) bad++;
    n_tests++;
    if (bad != 0 || se != 0) begin n_fail++; $display("FAIL short_data: got %0d bad words, %0d stall errors, expected 0", bad, se); end
    n_tests++;
    if (DMA0_Ready !== 1'b1) begin n_fail++; $display("FAIL short_ready_back: got %b expected 1", DMA0_Ready); end
  endtask

  task automatic test_host_cmd();
    bit to;
    hq.delete(); hq.push_back(16'h0011);
    host_send(1'b0, to);
    n_tests++;
    if (to || DMA1_Ready !== 1'b1 || DMA1_Watermark !== 1'b1 || h_rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL cmd_avail: got ready=%b wm=%b rx_ready=%b expected 1 1 0", DMA1_Ready, DMA1_Watermark, h_rx_ready);
    end
    OE = 1'b1; RD = 1'b1;
    tick();
    RD = 1'b0;
    repeat (RD_LAT - 1) tick();
    n_tests++;
    if (DQ !== 16'h0000 || DMA1_Ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_early: got dq=%h ready=%b expected 0000 1", DQ, DMA1_Ready);
    end
    tick();
    n_tests++;
    if (DQ !== 16'h0011) begin n_fail++; $display("FAIL cmd_dq: got %h expected 0011", DQ); end
    n_tests++;
    if ({DMA1_Ready, DMA1_Watermark, h_rx_ready} !== 3'b001) begin
      n_fail++; $display("FAIL cmd_done: got %b expected 001", {DMA1_Ready, DMA1_Watermark, h_rx_ready});
    end
    OE = 1'b0;
  endtask

  task automatic test_random_loopback();
    bit to; int se, bad, len;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 48);
      wr_q.delete();
      for (int i = 0; i < len; i++) wr_q.push_back(16'($urandom));
      write_words(0, 1'b1, 1'b1);
      drain_collect(1000, to, se);
      bad = 0;
      for (int i = 0; i < got_data.size() && i < len; i++)
        if (got_data[i] !== wr_q[i] || got_last[i] !== (i == len - 1)) bad++;
      n_tests++;
      if (to || got_data.size() != len || bad != 0 || se != 0) begin
        n_fail++; $display("FAIL loopback_pkt%0d: got %0d words (%0d bad, %0d stall) expected %0d", p, got_data.size(), bad, se, len);
      end
      n_tests++;
      if (DMA0_Ready !== 1'b1) begin n_fail++; $display("FAIL loopback_ready%0d: got %b expected 1", p, DMA0_Ready); end
    end
  endtask

  task automatic test_random_cmd();
    bit to; int len, rem, issued, cyc, guard, bad, fbad;
    int due[$];
    logic [15:0] last_word;
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(1, 12);
      hq.delete();
      for (int i = 0; i < len; i++) hq.push_back(16'($urandom));
      host_send(1'b1, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL cmd_load%0d: got timeout expected accept", p); end
      OE = 1'b1; rem = len; issued = 0; cyc = 0; guard = 0; bad = 0; fbad = 0;
      due.delete();
      while ((issued < len || due.size() > 0) && guard < 500) begin
        while (due.size() > 0 && due[0] == cyc) begin
          void'(due.pop_front());
          rem--;
          if (DQ !== hq[len - rem - 1]) bad++;
        end
        if (DMA1_Ready !== (rem > 0) || DMA1_Watermark !== (rem > 0 && rem <= WM_WORDS)) fbad++;
        if (issued < len && ($urandom % 2 == 1)) begin
          RD = 1'b1; issued++; due.push_back(cyc + RD_LAT + 1);
        end else RD = 1'b0;
        tick(); cyc++; guard++;
      end
      RD = 1'b0;
      n_tests++;
      if (guard >= 500 || bad != 0) begin n_fail++; $display("FAIL cmd_data%0d: got %0d bad words expected 0", p, bad); end
      n_tests++;
      if (fbad != 0) begin n_fail++; $display("FAIL cmd_flags%0d: got %0d flag errors expected 0", p, fbad); end
      last_word = hq[len - 1];
      RD = 1'b1; tick(); RD = 1'b0;
      repeat (RD_LAT + 1) tick();
      n_tests++;
      if (DQ !== last_word || DMA1_Ready !== 1'b0 || h_rx_ready !== 1'b1) begin
        n_fail++; $display("FAIL cmd_empty_rd%0d: got dq=%h ready=%b expected %h 0", p, DQ, DMA1_Ready, last_word);
      end
      OE = 1'b0;
    end
  endtask

  task automatic test_full_buffer();
    bit to; int se, bad, wm_bad;
    wr_q.delete();
    for (int i = 0; i < BUF_WORDS; i++) wr_q.push_back(16'($urandom));
    wm_bad = 0;
    for (int i = 0; i < BUF_WORDS; i++) begin
      if (DMA0_Watermark !== (i >= BUF_WORDS - WM_WORDS) || DMA0_Ready !== 1'b1) wm_bad++;
      if (i == BUF_WORDS - WM_WORDS) begin
        n_tests++;
        if (DMA0_Watermark !== 1'b1) begin n_fail++; $display("FAIL wm_rise: got %b expected 1", DMA0_Watermark); end
      end
      WR = 1'b1; tb_dq_en = 1'b1; tb_dq = wr_q[i]; LastWRData = 1'b0;
      tick();
    end
    WR = 1'b0; tb_dq_en = 1'b0;
    n_tests++;
    if (wm_bad != 0) begin n_fail++; $display("FAIL wm_track: got %0d flag errors expected 0", wm_bad); end
    n_tests++;
    if (DMA0_Ready !== 1'b0 || DMA0_Watermark !== 1'b0 || err_ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_commit: got ready=%b wm=%b ovf=%b expected 0 0 0", DMA0_Ready, DMA0_Watermark, err_ovf);
    end
    WR = 1'b1; tb_dq_en = 1'b1; tb_dq = 16'hDEAD;
    tick();
    WR = 1'b0; tb_dq_en = 1'b0;
    n_tests++;
    if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
    drain_collect(6000, to, se);
    bad = 0;
    for (int i = 0; i < got_data.size() && i < BUF_WORDS; i++)
      if (got_data[i] !== wr_q[i] || got_last[i] !== (i == BUF_WORDS - 1)) bad++;
    n_tests++;
    if (to || got_data.size() != BUF_WORDS || bad != 0 || se != 0) begin
      n_fail++; $display("FAIL full_drain: got %0d words (%0d bad) expected %0d", got_data.size(), bad, BUF_WORDS);
    end
  endtask

  task automatic test_proto();
    bit to; int se, bad;
    n_tests++;
    if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_clear: got %b expected 0", err_proto); end
    wr_q.delete();
    for (int i = 0; i < 3; i++) wr_q.push_back(16'($urandom));
    write_words(0, 1'b0, 1'b0);
    WR = 1'b1; RD = 1'b1; tb_dq_en = 1'b1; tb_dq = 16'hBAD0;
    tick();
    WR = 1'b0; RD = 1'b0; tb_dq_en = 1'b0;
    n_tests++;
    if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b expected 1", err_proto); end
    wr_q.push_back(16'($urandom));
    write_words(3, 1'b1, 1'b0);
    drain_collect(200, to, se);
    bad = 0;
    for (int i = 0; i < got_data.size() && i < 4; i++) if (got_data[i] !== wr_q[i]) bad++;
    n_tests++;
    if (to || got_data.size() != 4 || bad != 0) begin
      n_fail++; $display("FAIL proto_cnt0: got %0d words (%0d bad) expected 4", got_data.size(), bad);
    end
    hq.delete();
    for (int i = 0; i < 3; i++) hq.push_back(16'($urandom));
    host_send(1'b0, to);
    WR = 1'b1; RD = 1'b1;
    tick();
    WR = 1'b0; RD = 1'b0;
    repeat (RD_LAT + 1) tick();
    n_tests++;
    if (to || DMA1_Ready !== 1'b1 || DMA1_Watermark !== 1'b1) begin
      n_fail++; $display("FAIL proto_cnt1_flags: got ready=%b wm=%b expected 1 1", DMA1_Ready, DMA1_Watermark);
    end
    OE = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      RD = 1'b1; tick(); RD = 1'b0;
      repeat (RD_LAT) tick();
      if (DQ !== hq[k]) bad++;
    end
    n_tests++;
    if (bad != 0 || DMA1_Ready !== 1'b0) begin
      n_fail++; $display("FAIL proto_cnt1_data: got %0d bad words ready=%b expected 0 0", bad, DMA1_Ready);
    end
    OE = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    bit to; int se, bad;
    wr_q.delete();
    for (int i = 0; i < 300; i++) wr_q.push_back(16'($urandom));
    write_words(0, 1'b1, 1'b0);
    h_tx_ready = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (h_tx_valid !== 1'b1) begin n_fail++; $display("FAIL middrain_active: got valid=%b expected 1", h_tx_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark, h_tx_valid, h_tx_last,
         h_rx_ready, err_ovf, err_proto} !== 9'b0 || h_tx_data !== 16'h0) begin
      n_fail++; $display("FAIL middrain_reset: outputs not cleared, valid=%b data=%h ovf=%b", h_tx_valid, h_tx_data, err_ovf);
    end
    h_tx_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr_q.delete();
    for (int i = 0; i < 4; i++) wr_q.push_back(16'($urandom));
    write_words(0, 1'b1, 1'b1);
    drain_collect(200, to, se);
    bad = 0;
    for (int i = 0; i < got_data.size() && i < 4; i++)
      if (got_data[i] !== wr_q[i] || got_last[i] !== (i == 3)) bad++;
    n_tests++;
    if (to || got_data.size() != 4 || bad != 0 || se != 0) begin
      n_fail++; $display("FAIL fresh_packet: got %0d words (%0d bad) expected 4", got_data.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_short_packet();
    test_host_cmd();
    test_random_loopback();
    test_random_cmd();
    test_full_buffer();
    test_proto();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
